// File: rtl/d16_pkg.sv
// d16_pkg: shared constants and helpers for the register write-back path.
package d16_pkg;
   localparam int WB_ALU    = 0;
   localparam int WB_MEM    = 1;
   localparam int WB_DBG    = 2;
   localparam int NUM_WB    = 3;
   localparam int REG_W     = 16;
   localparam int REG_SEL_W = 3;

   // Round-robin successor over the three producers.
   function automatic logic [1:0] wb_next(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction
endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// wb_slot: one-entry write-back buffer; a fresh accept wins over a same-edge clear.
import d16_pkg::*;

module wb_slot #(
   parameter int DATA_W = REG_W,
   parameter int SEL_W  = REG_SEL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   input  logic              clear,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic [DATA_W-1:0] in_data,
   output logic              full,
   output logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] data
);
   logic              full_q, full_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      full_d = accept | (full_q & ~clear);
      sel_d  = accept ? in_sel : sel_q;
      data_d = accept ? in_data : data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         sel_q  <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         sel_q  <= sel_d;
         data_q <= data_d;
      end
   end

   assign full = full_q;
   assign sel  = sel_q;
   assign data = data_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: buffers one write per producer and issues up to two
// non-conflicting writes per cycle to the register unit, round-robin.
import d16_pkg::*;

module regfile_wb_arbiter #(
   parameter int DATA_W = REG_W,
   parameter int SEL_W  = REG_SEL_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hold,
   input  logic [NUM_WB-1:0]        req_valid,
   output logic [NUM_WB-1:0]        req_ready,
   input  logic [NUM_WB*SEL_W-1:0]  req_sel,
   input  logic [NUM_WB*DATA_W-1:0] req_data,
   output logic [NUM_WB-1:0]        wb_done,
   output logic                     rf_en,
   output logic                     rf_wr_en,
   output logic [SEL_W-1:0]         rf_rD_sel,
   output logic [DATA_W-1:0]        rf_rD_data_in,
   output logic                     rf_rS_wr_en,
   output logic [SEL_W-1:0]         rf_rS_sel,
   output logic [DATA_W-1:0]        rf_rS_data_in,
   output logic                     busy
);
   logic [NUM_WB-1:0] full, accept;
   logic [SEL_W-1:0]  sel  [NUM_WB];
   logic [DATA_W-1:0] data [NUM_WB];
   logic [1:0]        rr_q, rr_d;
   logic              rf_en_q, rf_en_d;
   logic              allow, d_gnt, s_gnt;
   logic [1:0]        d_idx, s_idx, idx;

   for (genvar g = 0; g < NUM_WB; g++) begin : g_slot
      wb_slot #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_slot (
         .clk     (clk),
         .rst     (rst),
         .accept  (accept[g]),
         .clear   (wb_done[g]),
         .in_sel  (req_sel[g*SEL_W +: SEL_W]),
         .in_data (req_data[g*DATA_W +: DATA_W]),
         .full    (full[g]),
         .sel     (sel[g]),
         .data    (data[g])
      );
   end

   assign allow = rf_en_q & ~hold & ~rst;

   // Scan from rr: first full slot takes rD, next full slot to a different register takes rS.
   always_comb begin
      d_gnt = 1'b0;
      s_gnt = 1'b0;
      d_idx = rr_q;
      s_idx = rr_q;
      idx   = rr_q;
      for (int k = 0; k < NUM_WB; k++) begin
         if (allow && full[idx] && !d_gnt) begin
            d_gnt = 1'b1;
            d_idx = idx;
         end else if (allow && full[idx] && !s_gnt && sel[idx] != sel[d_idx]) begin
            s_gnt = 1'b1;
            s_idx = idx;
         end
         idx = wb_next(idx);
      end
   end

   always_comb begin
      wb_done = '0;
      if (d_gnt) wb_done[d_idx] = 1'b1;
      if (s_gnt) wb_done[s_idx] = 1'b1;
      rf_wr_en      = d_gnt;
      rf_rD_sel     = d_gnt ? sel[d_idx] : '0;
      rf_rD_data_in = d_gnt ? data[d_idx] : '0;
      rf_rS_wr_en   = s_gnt;
      rf_rS_sel     = s_gnt ? sel[s_idx] : '0;
      rf_rS_data_in = s_gnt ? data[s_idx] : '0;
      req_ready     = (rf_en_q && !rst) ? (~full | wb_done) : '0;
      accept        = req_valid & req_ready;
      busy          = |full;
      rr_d          = s_gnt ? wb_next(s_idx) : d_gnt ? wb_next(d_idx) : rr_q;
      rf_en_d       = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q    <= 2'd0;
         rf_en_q <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         rf_en_q <= rf_en_d;
      end
   end

   assign rf_en = rf_en_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random stimulus checked against a
// queue-based model of the write-back arbiter.
module tb_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst, hold;
   logic [2:0]  req_valid, req_ready, wb_done;
   logic [8:0]  req_sel;
   logic [47:0] req_data;
   logic        rf_en, rf_wr_en, rf_rS_wr_en, busy;
   logic [2:0]  rf_rD_sel, rf_rS_sel;
   logic [15:0] rf_rD_data_in, rf_rS_data_in;

   int checks = 0;
   int errors = 0;

   bit          mfull [3];
   logic [2:0]  msel  [3];
   logic [15:0] mdata [3];
   int          mrr;
   bit          mrf_en;
   logic [15:0] dreg  [8];
   int          gd, gs;
   logic [2:0]  exp_done, exp_ready;
   logic [19:0] exp_rd, exp_rs;
   logic        exp_busy;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .hold          (hold),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_sel       (req_sel),
      .req_data      (req_data),
      .wb_done       (wb_done),
      .rf_en         (rf_en),
      .rf_wr_en      (rf_wr_en),
      .rf_rD_sel     (rf_rD_sel),
      .rf_rD_data_in (rf_rD_data_in),
      .rf_rS_wr_en   (rf_rS_wr_en),
      .rf_rS_sel     (rf_rS_sel),
      .rf_rS_data_in (rf_rS_data_in),
      .busy          (busy)
   );

   function automatic void model_expect();
      int order[$];
      gd = -1;
      gs = -1;
      for (int k = 0; k < 3; k++)
         if (mfull[(mrr + k) % 3]) order.push_back((mrr + k) % 3);
      if (!hold && !rst && mrf_en && order.size() > 0) begin
         gd = order[0];
         for (int j = 1; j < order.size(); j++)
            if (gs < 0 && msel[order[j]] != msel[gd]) gs = order[j];
      end
      exp_done = 3'b000;
      exp_rd   = '0;
      exp_rs   = '0;
      if (gd >= 0) begin
         exp_done[gd] = 1'b1;
         exp_rd = {1'b1, msel[gd], mdata[gd]};
      end
      if (gs >= 0) begin
         exp_done[gs] = 1'b1;
         exp_rs = {1'b1, msel[gs], mdata[gs]};
      end
      for (int i = 0; i < 3; i++)
         exp_ready[i] = !rst && mrf_en && (!mfull[i] || exp_done[i]);
      exp_busy = mfull[0] || mfull[1] || mfull[2];
   endfunction

   task automatic drive(input logic [2:0] v, input logic [8:0] s, input logic [47:0] d,
                        input logic h, input logic r);
      req_valid = v;
      req_sel   = s;
      req_data  = d;
      hold      = h;
      rst       = r;
      #4;
      model_expect();
   endtask

   task automatic advance();
      if (rf_wr_en) dreg[rf_rD_sel] = rf_rD_data_in;
      if (rf_rS_wr_en) dreg[rf_rS_sel] = rf_rS_data_in;
      for (int i = 0; i < 3; i++) begin
         if (rst) mfull[i] = 1'b0;
         else if (req_valid[i] && exp_ready[i]) begin
            mfull[i] = 1'b1;
            msel[i]  = req_sel[i*3 +: 3];
            mdata[i] = req_data[i*16 +: 16];
         end else if (exp_done[i]) mfull[i] = 1'b0;
      end
      if (rst) mrr = 0;
      else if (gs >= 0) mrr = (gs + 1) % 3;
      else if (gd >= 0) mrr = (gd + 1) % 3;
      mrf_en = !rst;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(3'b000, '0, '0, 1'b0, 1'b1);
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      advance();
   endtask

   task automatic test_reset();
      drive(3'b000, '0, '0, 1'b0, 1'b1);
      checks++;
      if (req_ready !== 3'b000) begin errors++; $display("FAIL reset ready got %b want 000", req_ready); end
      checks++;
      if ({wb_done, rf_wr_en, rf_rS_wr_en, busy, rf_en} !== 7'b0) begin
         errors++; $display("FAIL reset outputs got %b want 0", {wb_done, rf_wr_en, rf_rS_wr_en, busy, rf_en});
      end
      checks++;
      if ({rf_rD_sel, rf_rD_data_in, rf_rS_sel, rf_rS_data_in} !== 38'b0) begin
         errors++; $display("FAIL reset ports got %h want 0", {rf_rD_sel, rf_rD_data_in, rf_rS_sel, rf_rS_data_in});
      end
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({rf_en, req_ready} !== 4'b0000) begin errors++; $display("FAIL reset first_cycle got %b want 0000", {rf_en, req_ready}); end
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({rf_en, req_ready} !== 4'b1111) begin errors++; $display("FAIL reset rf_en_up got %b want 1111", {rf_en, req_ready}); end
      advance();
   endtask

   task automatic test_single();
      do_reset();
      drive(3'b001, {6'd0, 3'd1}, {32'd0, 16'hfeed}, 1'b0, 1'b0);
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({rf_wr_en, rf_rD_sel, rf_rD_data_in} !== {1'b1, 3'd1, 16'hfeed}) begin
         errors++; $display("FAIL single rd got %h want %h", {rf_wr_en, rf_rD_sel, rf_rD_data_in}, {1'b1, 3'd1, 16'hfeed});
      end
      checks++;
      if (wb_done !== 3'b001) begin errors++; $display("FAIL single wb_done got %b want 001", wb_done); end
      advance();
      checks++;
      if (dreg[1] !== 16'hfeed) begin errors++; $display("FAIL single readback got %h want feed", dreg[1]); end
   endtask

   task automatic test_dual();
      do_reset();
      drive(3'b011, {3'd0, 3'd2, 3'd0}, {16'd0, 16'h1234, 16'hbeef}, 1'b0, 1'b0);
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({rf_wr_en, rf_rD_sel, rf_rD_data_in} !== {1'b1, 3'd0, 16'hbeef}) begin
         errors++; $display("FAIL dual rd got %h want %h", {rf_wr_en, rf_rD_sel, rf_rD_data_in}, {1'b1, 3'd0, 16'hbeef});
      end
      checks++;
      if ({rf_rS_wr_en, rf_rS_sel, rf_rS_data_in} !== {1'b1, 3'd2, 16'h1234}) begin
         errors++; $display("FAIL dual rs got %h want %h", {rf_rS_wr_en, rf_rS_sel, rf_rS_data_in}, {1'b1, 3'd2, 16'h1234});
      end
      checks++;
      if (wb_done !== 3'b011) begin errors++; $display("FAIL dual wb_done got %b want 011", wb_done); end
      advance();
      // rr is now 2: DBG then ALU order, both different registers
      drive(3'b101, {3'd6, 3'd0, 3'd5}, {16'h2222, 16'd0, 16'h1111}, 1'b0, 1'b0);
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({rf_rD_sel, rf_rS_sel} !== {3'd6, 3'd5}) begin
         errors++; $display("FAIL dual rr_order got %h want %h", {rf_rD_sel, rf_rS_sel}, {3'd6, 3'd5});
      end
      advance();
   endtask

   task automatic test_conflict();
      do_reset();
      drive(3'b011, {3'd0, 3'd3, 3'd3}, {16'd0, 16'h0002, 16'h0001}, 1'b0, 1'b0);
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({rf_wr_en, rf_rD_sel, rf_rD_data_in, rf_rS_wr_en} !== {1'b1, 3'd3, 16'h0001, 1'b0}) begin
         errors++; $display("FAIL conflict c1 got %h want %h", {rf_wr_en, rf_rD_sel, rf_rD_data_in, rf_rS_wr_en}, {1'b1, 3'd3, 16'h0001, 1'b0});
      end
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({rf_wr_en, rf_rD_sel, rf_rD_data_in} !== {1'b1, 3'd3, 16'h0002}) begin
         errors++; $display("FAIL conflict c2 got %h want %h", {rf_wr_en, rf_rD_sel, rf_rD_data_in}, {1'b1, 3'd3, 16'h0002});
      end
      advance();
      checks++;
      if (dreg[3] !== 16'h0002) begin errors++; $display("FAIL conflict final got %h want 0002", dreg[3]); end
   endtask

   task automatic test_hold();
      do_reset();
      drive(3'b111, {3'd6, 3'd5, 3'd4}, {16'h6666, 16'h5555, 16'h4444}, 1'b1, 1'b0);
      advance();
      for (int c = 0; c < 3; c++) begin
         drive(3'b000, '0, '0, 1'b1, 1'b0);
         checks++;
         if ({rf_wr_en, rf_rS_wr_en, busy, req_ready} !== 6'b001000) begin
            errors++; $display("FAIL hold frozen got %b want 001000", {rf_wr_en, rf_rS_wr_en, busy, req_ready});
         end
         advance();
      end
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ($countones(wb_done) != 2 || {rf_wr_en, rf_rS_wr_en} !== 2'b11) begin
         errors++; $display("FAIL hold release got %b want two grants", wb_done);
      end
      checks++;
      if ({wb_done, exp_rd, exp_rs} !== {exp_done, rf_wr_en, rf_rD_sel, rf_rD_data_in, rf_rS_wr_en, rf_rS_sel, rf_rS_data_in}) begin
         errors++; $display("FAIL hold ports got %h want %h", {wb_done, rf_wr_en, rf_rD_sel, rf_rD_data_in, rf_rS_wr_en, rf_rS_sel, rf_rS_data_in}, {exp_done, exp_rd, exp_rs});
      end
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({rf_wr_en, rf_rS_wr_en, rf_rD_sel} !== {2'b10, exp_rd[18:16]}) begin
         errors++; $display("FAIL hold third got %b want %b", {rf_wr_en, rf_rS_wr_en, rf_rD_sel}, {2'b10, exp_rd[18:16]});
      end
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL hold busy_clear got %b want 0", busy); end
      advance();
   endtask

   task automatic test_stream();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         drive(3'b001, {6'd0, 3'd7}, {32'd0, 16'h0100 + 16'(k)}, 1'b0, 1'b0);
         checks++;
         if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL stream ready got %b want 1", req_ready[0]); end
         if (k > 0) begin
            checks++;
            if ({rf_wr_en, rf_rD_sel, rf_rD_data_in} !== {1'b1, 3'd7, 16'h0100 + 16'(k - 1)}) begin
               errors++; $display("FAIL stream rd got %h want %h", {rf_wr_en, rf_rD_sel, rf_rD_data_in}, {1'b1, 3'd7, 16'h0100 + 16'(k - 1)});
            end
         end
         advance();
      end
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      advance();
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(3'b010, {3'd0, 3'd5, 3'd0}, {16'd0, 16'habcd, 16'd0}, 1'b1, 1'b0);
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b1);
      checks++;
      if ({wb_done, rf_wr_en, rf_rS_wr_en, req_ready} !== 8'b0) begin
         errors++; $display("FAIL rstmid during got %b want 0", {wb_done, rf_wr_en, rf_rS_wr_en, req_ready});
      end
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({wb_done, rf_wr_en, busy, rf_en, req_ready} !== 9'b0) begin
         errors++; $display("FAIL rstmid after got %b want 0", {wb_done, rf_wr_en, busy, rf_en, req_ready});
      end
      advance();
      drive(3'b000, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({rf_wr_en, busy, rf_en, req_ready} !== 6'b001111) begin
         errors++; $display("FAIL rstmid resume got %b want 001111", {rf_wr_en, busy, rf_en, req_ready});
      end
      advance();
   endtask

   task automatic test_random();
      logic [8:0]  s;
      logic [47:0] d;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 3; i++) s[i*3 +: 3] = 3'($urandom_range(0, 3));
         d = {16'($urandom), 16'($urandom), 16'($urandom)};
         drive(3'($urandom), s, d, $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0);
         checks++;
         if (wb_done !== exp_done) begin errors++; $display("FAIL rand wb_done c%0d got %b want %b", c, wb_done, exp_done); end
         checks++;
         if ({rf_wr_en, rf_rD_sel, rf_rD_data_in} !== exp_rd) begin
            errors++; $display("FAIL rand rd c%0d got %h want %h", c, {rf_wr_en, rf_rD_sel, rf_rD_data_in}, exp_rd);
         end
         checks++;
         if ({rf_rS_wr_en, rf_rS_sel, rf_rS_data_in} !== exp_rs) begin
            errors++; $display("FAIL rand rs c%0d got %h want %h", c, {rf_rS_wr_en, rf_rS_sel, rf_rS_data_in}, exp_rs);
         end
         checks++;
         if ({req_ready, busy} !== {exp_ready, exp_busy}) begin
            errors++; $display("FAIL rand ready_busy c%0d got %b want %b", c, {req_ready, busy}, {exp_ready, exp_busy});
         end
         advance();
      end
   endtask

   initial begin
      req_valid = '0;
      req_sel   = '0;
      req_data  = '0;
      hold      = 1'b0;
      rst       = 1'b1;
      mrr       = 0;
      mrf_en    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mfull[i] = 1'b0;
         msel[i]  = '0;
         mdata[i] = '0;
      end
      for (int r = 0; r < 8; r++) dreg[r] = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_dual();
      test_conflict();
      test_hold();
      test_stream();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
